// File: rtl/barrel_shifter_pipe_nb.sv
// Pipelined barrel shifter (LSL/LSR/ROL/ASR) with carry-in fill and carry-out capture.
// Right shifts run as left rotates of a bit-reversed {operand, fill} pair; one register per stage.
module barrel_shifter_pipe_nb #(
   parameter  int WIDTH = 8,
   localparam int SH_W  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in,
   input  logic [WIDTH-1:0] cin,
   input  logic [SH_W-1:0]  sh,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] cout
);
   localparam int DW = 2 * WIDTH;
   localparam logic [1:0] MODE_LSL = 2'b00;
   localparam logic [1:0] MODE_LSR = 2'b01;
   localparam logic [1:0] MODE_ROL = 2'b10;
   localparam logic [1:0] MODE_ASR = 2'b11;

   function automatic logic [WIDTH-1:0] rev_fn(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      r = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = v[WIDTH-1-i];
      end
      return r;
   endfunction

   // Upper half is the result; lower half holds the rotated-out bits, trimmed to the shift count.
   function automatic logic [DW-1:0] finish_fn(input logic [DW-1:0]    v,
                                               input logic [WIDTH-1:0] m,
                                               input logic [1:0]       md);
      logic [WIDTH-1:0] hi;
      logic [WIDTH-1:0] lo;
      hi = v[DW-1:WIDTH];
      lo = v[WIDTH-1:0] & m;
      if (md[0]) begin
         hi = rev_fn(hi);
         lo = rev_fn(lo);
      end else begin
         hi = hi;
         lo = lo;
      end
      if (md == MODE_ROL) begin
         lo = {WIDTH{1'b0}};
      end else begin
         lo = lo;
      end
      return {hi, lo};
   endfunction

   logic                  adv_s;
   logic [DW-1:0]         pre_v_s;
   logic [DW-1:0]         v_in_s   [SH_W];
   logic [DW-1:0]         rot_v_s  [SH_W];
   logic [DW-1:0]         load_v_s [SH_W];
   logic [WIDTH-1:0]      m_in_s   [SH_W];
   logic [WIDTH-1:0]      rot_m_s  [SH_W];
   logic [1:0]            md_in_s  [SH_W];
   logic                  b_in_s   [SH_W];
   logic [SH_W-2:0]       sh_in_s  [1:SH_W-1];

   logic [SH_W-1:0]       valid_r;
   logic [DW-1:0]         data_r   [SH_W];
   logic [WIDTH-1:0]      mask_r   [1:SH_W-1];
   logic [1:0]            mode_r   [1:SH_W-1];
   logic [SH_W-2:0]       sh_r     [1:SH_W-1];

   assign adv_s     = out_ready || !valid_r[0];
   assign in_ready  = adv_s;
   assign out_valid = valid_r[0];
   assign out       = data_r[0][DW-1:WIDTH];
   assign cout      = data_r[0][WIDTH-1:0];

   // Map every mode onto a left rotate of {operand, fill}.
   always_comb begin
      pre_v_s = {in, cin};
      case (mode)
         MODE_LSL: pre_v_s = {in, cin};
         MODE_LSR: pre_v_s = {rev_fn(in), rev_fn(cin)};
         MODE_ROL: pre_v_s = {in, in};
         MODE_ASR: pre_v_s = {rev_fn(in), {WIDTH{in[WIDTH-1]}}};
         default:  pre_v_s = {in, cin};
      endcase
   end

   for (genvar k = 0; k < SH_W; k++) begin : g_stage
      localparam int D = 1 << k;

      if (k == SH_W - 1) begin : g_first
         assign v_in_s[k]  = pre_v_s;
         assign m_in_s[k]  = {WIDTH{1'b0}};
         assign md_in_s[k] = mode;
         assign b_in_s[k]  = sh[k];
         assign sh_in_s[k] = sh[SH_W-2:0];
      end else begin : g_next
         assign v_in_s[k]  = data_r[k+1];
         assign m_in_s[k]  = mask_r[k+1];
         assign md_in_s[k] = mode_r[k+1];
         assign b_in_s[k]  = sh_r[k+1][k];
         if (k > 0) begin : g_sh
            assign sh_in_s[k] = sh_r[k+1];
         end
      end

      // The mask grows by D ones each time this stage actually shifts.
      assign rot_v_s[k] = b_in_s[k] ? {v_in_s[k][DW-1-D:0], v_in_s[k][DW-1 -: D]} : v_in_s[k];
      assign rot_m_s[k] = b_in_s[k] ? {m_in_s[k][WIDTH-1-D:0], {D{1'b1}}} : m_in_s[k];

      if (k == 0) begin : g_last
         assign load_v_s[k] = finish_fn(rot_v_s[k], rot_m_s[k], md_in_s[k]);
      end else begin : g_mid
         assign load_v_s[k] = rot_v_s[k];
      end
   end

   // Stage registers: async clear, flush drops valids only, everything else moves on adv.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= {SH_W{1'b0}};
         for (int k = 0; k < SH_W; k++) begin
            data_r[k] <= {DW{1'b0}};
         end
         for (int k = 1; k < SH_W; k++) begin
            mask_r[k] <= {WIDTH{1'b0}};
            mode_r[k] <= 2'b00;
            sh_r[k]   <= {(SH_W-1){1'b0}};
         end
      end else if (flush) begin
         valid_r <= {SH_W{1'b0}};
      end else if (adv_s) begin
         valid_r <= {in_valid, valid_r[SH_W-1:1]};
         for (int k = 0; k < SH_W; k++) begin
            data_r[k] <= load_v_s[k];
         end
         for (int k = 1; k < SH_W; k++) begin
            mask_r[k] <= rot_m_s[k];
            mode_r[k] <= md_in_s[k];
            sh_r[k]   <= sh_in_s[k];
         end
      end
   end

endmodule

// File: tb/tb_barrel_shifter_pipe_nb.sv
// Directed bench for barrel_shifter_pipe_nb: WIDTH=8 instance for function/flow control,
// plus WIDTH 4/16/32 instances swept against the mode equations.
module tb_barrel_shifter_pipe_nb;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [7:0] in_d, cin_d, out_d, cout_d;
   logic [2:0] sh;
   logic [1:0] mode;

   logic        sw_valid, sw_ready;
   logic [1:0]  sw_mode;
   logic [3:0]  s4_in, s4_cin, s4_out, s4_cout;
   logic [1:0]  s4_sh;
   logic        s4_ir, s4_ov;
   logic [15:0] s16_in, s16_cin, s16_out, s16_cout;
   logic [3:0]  s16_sh;
   logic        s16_ir, s16_ov;
   logic [31:0] s32_in, s32_cin, s32_out, s32_cout;
   logic [4:0]  s32_sh;
   logic        s32_ir, s32_ov;

   int n_cmp = 0;
   int n_err = 0;

   barrel_shifter_pipe_nb #(.WIDTH(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in(in_d), .cin(cin_d), .sh(sh), .mode(mode), .out_valid(out_valid),
      .out_ready(out_ready), .out(out_d), .cout(cout_d));

   barrel_shifter_pipe_nb #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(sw_valid), .in_ready(s4_ir),
      .in(s4_in), .cin(s4_cin), .sh(s4_sh), .mode(sw_mode), .out_valid(s4_ov),
      .out_ready(sw_ready), .out(s4_out), .cout(s4_cout));

   barrel_shifter_pipe_nb #(.WIDTH(16)) u_w16 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(sw_valid), .in_ready(s16_ir),
      .in(s16_in), .cin(s16_cin), .sh(s16_sh), .mode(sw_mode), .out_valid(s16_ov),
      .out_ready(sw_ready), .out(s16_out), .cout(s16_cout));

   barrel_shifter_pipe_nb #(.WIDTH(32)) u_w32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(sw_valid), .in_ready(s32_ir),
      .in(s32_in), .cin(s32_cin), .sh(s32_sh), .mode(sw_mode), .out_valid(s32_ov),
      .out_ready(sw_ready), .out(s32_out), .cout(s32_cout));

   // Reference model: the mode equations evaluated on w-bit values held in 64 bits.
   function automatic logic [127:0] ref_fn(input int w, input logic [63:0] a,
                                           input logic [63:0] c, input int s,
                                           input logic [1:0] md);
      logic [63:0] msk, o, co;
      msk = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      if (s == 0) return {a & msk, 64'd0};
      case (md)
         2'b00: begin o = (a << s) | (c >> (w - s)); co = a >> (w - s); end
         2'b01: begin o = (a >> s) | (c << (w - s)); co = a << (w - s); end
         2'b10: begin o = (a << s) | (a >> (w - s)); co = 64'd0; end
         default: begin
            o  = (a >> s) | (a[w-1] ? (msk & ~(msk >> s)) : 64'd0);
            co = a << (w - s);
         end
      endcase
      return {o & msk, co & msk};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One operand through the 8-bit pipe with out_ready high; checks latency and result.
   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] c,
                       input logic [2:0] s, input logic [1:0] md,
                       input logic [7:0] eo, input logic [7:0] ec);
      @(negedge clk);
      in_valid = 1'b1; in_d = a; cin_d = c; sh = s; mode = md;
      @(negedge clk);
      in_valid = 1'b0; in_d = 8'h5A; cin_d = 8'hFF; sh = 3'd7; mode = 2'b01;
      chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      chk({tag, "_lat2"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_out"}, 64'(out_d), 64'(eo));
      chk({tag, "_cout"}, 64'(cout_d), 64'(ec));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100000");
      $fatal(1);
   end

   initial begin
      logic [127:0] r;
      logic [15:0]  held;
      logic         stale;
      int idx, rx, stall_left;
      logic stalled;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_d = 8'h00; cin_d = 8'h00; sh = 3'd0; mode = 2'b00;
      sw_valid = 1'b0; sw_ready = 1'b0; sw_mode = 2'b00;
      s4_in = 4'h0; s4_cin = 4'h0; s4_sh = 2'd0;
      s16_in = 16'h0; s16_cin = 16'h0; s16_sh = 4'd0;
      s32_in = 32'h0; s32_cin = 32'h0; s32_sh = 5'd0;

      repeat (2) @(negedge clk);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_out", 64'(out_d), 64'd0);
      chk("rst_cout", 64'(cout_d), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      rst_n = 1'b1;

      run8("lsl3", 8'hB5, 8'hC3, 3'd3, 2'b00, 8'hAE, 8'h05);
      run8("lsl0", 8'hB5, 8'hC3, 3'd0, 2'b00, 8'hB5, 8'h00);
      run8("lsr3", 8'hB5, 8'hC3, 3'd3, 2'b01, 8'h76, 8'hA0);
      run8("asr3", 8'hB5, 8'hC3, 3'd3, 2'b11, 8'hF6, 8'hA0);
      run8("rol3", 8'hB5, 8'hC3, 3'd3, 2'b10, 8'hAD, 8'h00);
      run8("lsr7", 8'h81, 8'h0F, 3'd7, 2'b01, 8'h1F, 8'h02);

      // Reset asserted with an operand in flight.
      @(negedge clk);
      in_valid = 1'b1; in_d = 8'hB5; cin_d = 8'hC3; sh = 3'd3; mode = 2'b00;
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", 64'(out_valid), 64'd0);
      chk("midrst_out", 64'(out_d), 64'd0);
      chk("midrst_cout", 64'(cout_d), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      stale = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) stale = 1'b1;
      end
      chk("midrst_no_stale", 64'(stale), 64'd0);
      run8("postrst", 8'h0F, 8'hF0, 3'd4, 2'b00, 8'hFF, 8'h00);

      // Six back-to-back operands with a 4-cycle stall at the first result.
      idx = 0; rx = 0; stall_left = 0; stalled = 1'b0; held = 16'h0000;
      for (int cyc = 0; cyc < 40 && rx < 6; cyc++) begin
         @(negedge clk);
         if (out_valid && !stalled) begin
            stall_left = 4;
            stalled = 1'b1;
         end
         out_ready = (stall_left == 0);
         if (idx < 6) begin
            in_valid = 1'b1; in_d = 8'(8'h30 + idx); cin_d = 8'hA5; sh = 3'(idx); mode = 2'b00;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out_valid && !out_ready) begin
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            if (stall_left == 4) held = {out_d, cout_d};
            else chk("stall_hold", 64'({out_d, cout_d}), 64'(held));
            stall_left--;
         end else if (out_valid) begin
            r = ref_fn(8, 64'(8'(8'h30 + rx)), 64'hA5, rx, 2'b00);
            chk($sformatf("stream_out_%0d", rx), 64'(out_d), r[127:64]);
            chk($sformatf("stream_cout_%0d", rx), 64'(cout_d), r[63:0]);
            rx++;
         end
         if (in_valid && in_ready) idx++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("stream_count", 64'(rx), 64'd6);
      chk("stream_stalled", 64'(stalled), 64'd1);
      stale = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) stale = 1'b1;
      end
      chk("stream_no_dup", 64'(stale), 64'd0);

      // flush with operands in flight and a new one presented on the flush edge.
      @(negedge clk);
      in_valid = 1'b1; in_d = 8'h11; cin_d = 8'h22; sh = 3'd1; mode = 2'b00;
      @(negedge clk);
      in_d = 8'h33;
      @(negedge clk);
      in_d = 8'h44; flush = 1'b1;
      #1 chk("flush_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      stale = 1'b0;
      repeat (6) begin
         if (out_valid) stale = 1'b1;
         @(negedge clk);
      end
      chk("flush_no_result", 64'(stale), 64'd0);
      run8("postflush", 8'hB5, 8'hC3, 3'd3, 2'b11, 8'hF6, 8'hA0);

      // Width sweep: first four vectors use sh = WIDTH-1 with the MSB set.
      for (int v = 0; v < 12; v++) begin
         @(negedge clk);
         sw_valid = 1'b1;
         sw_mode  = 2'(v % 4);
         s4_in  = 4'($urandom);  s4_cin  = 4'($urandom);  s4_sh  = 2'($urandom);
         s16_in = 16'($urandom); s16_cin = 16'($urandom); s16_sh = 4'($urandom);
         s32_in = $urandom;      s32_cin = $urandom;      s32_sh = 5'($urandom);
         if (v < 4) begin
            s4_in[3] = 1'b1; s16_in[15] = 1'b1; s32_in[31] = 1'b1;
            s4_sh = 2'd3; s16_sh = 4'd15; s32_sh = 5'd31;
         end
         @(negedge clk);
         sw_valid = 1'b0;
         repeat (6) @(negedge clk);
         r = ref_fn(4, 64'(s4_in), 64'(s4_cin), int'(s4_sh), sw_mode);
         chk($sformatf("w4_valid_%0d", v), 64'(s4_ov), 64'd1);
         chk($sformatf("w4_out_%0d", v), 64'(s4_out), r[127:64]);
         chk($sformatf("w4_cout_%0d", v), 64'(s4_cout), r[63:0]);
         r = ref_fn(16, 64'(s16_in), 64'(s16_cin), int'(s16_sh), sw_mode);
         chk($sformatf("w16_valid_%0d", v), 64'(s16_ov), 64'd1);
         chk($sformatf("w16_out_%0d", v), 64'(s16_out), r[127:64]);
         chk($sformatf("w16_cout_%0d", v), 64'(s16_cout), r[63:0]);
         r = ref_fn(32, 64'(s32_in), 64'(s32_cin), int'(s32_sh), sw_mode);
         chk($sformatf("w32_valid_%0d", v), 64'(s32_ov), 64'd1);
         chk($sformatf("w32_out_%0d", v), 64'(s32_out), r[127:64]);
         chk($sformatf("w32_cout_%0d", v), 64'(s32_cout), r[63:0]);
         sw_ready = 1'b1;
         @(negedge clk);
         sw_ready = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
